// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through instruction memory, hands words to decode,
// and handles stalls, jump redirects and a halt opcode.
module fetch_sequencer #(
    parameter int unsigned         PC_W     = 8,
    parameter int unsigned         CODE_W   = 8,
    parameter logic [PC_W-1:0]     RESET_PC = 8'h00,
    parameter logic [CODE_W-1:0]   HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              jflag,
    input  logic [PC_W-1:0]   jaddr,
    input  logic [CODE_W-1:0] imem_code,
    input  logic              instr_ready,
    output logic [PC_W-1:0]   imem_addr,
    output logic [CODE_W-1:0] instr,
    output logic [PC_W-1:0]   instr_pc,
    output logic              instr_valid,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        fetch_cnt
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            slot_free;

    assign imem_addr = pc;
    assign slot_free = !instr_valid || instr_ready;

    // Single-process FSM; busy/halted are kept as flops tracking the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            fetch_cnt   <= '0;
        end else if (state == IDLE) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            if (start) begin
                state     <= RUN;
                busy      <= 1'b1;
                fetch_cnt <= '0;
            end
        end else if (jflag) begin
            // Redirect wins over stall, load and halt detection; the pending word is flushed.
            state       <= REDIRECT;
            busy        <= 1'b1;
            halted      <= 1'b0;
            pc          <= jaddr;
            instr_valid <= 1'b0;
        end else if (state == REDIRECT) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (slot_free) begin
                instr       <= imem_code;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= PC_W'(pc + 1'b1);
                if (fetch_cnt != CNT_MAX) begin
                    fetch_cnt <= CNT_W'(fetch_cnt + 1'b1);
                end
                if (imem_code == HALT_OP) begin
                    state  <= HALT;
                    busy   <= 1'b0;
                    halted <= 1'b1;
                end
            end
        end else begin
            // HALT: only the delivered halt word may drain.
            if (instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       jflag;
    logic [7:0] jaddr;
    logic [7:0] imem_code;
    logic       instr_ready;
    logic [7:0] imem_addr;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       busy;
    logic       halted;
    logic [7:0] fetch_cnt;

    logic [7:0] mem [256];

    int vectors;
    int miscompares;

    typedef enum int {M_IDLE, M_RUN, M_REDIR, M_HALT} mode_t;
    mode_t      m_mode;
    logic [7:0] m_pc;
    logic [7:0] m_instr;
    logic [7:0] m_ipc;
    logic       m_valid;
    int         m_cnt;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .jflag       (jflag),
        .jaddr       (jaddr),
        .imem_code   (imem_code),
        .instr_ready (instr_ready),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .busy        (busy),
        .halted      (halted),
        .fetch_cnt   (fetch_cnt)
    );

    assign imem_code = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 8'h00;
        m_instr = 8'h00;
        m_ipc   = 8'h00;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    // Next state of the fetch unit from the rules: what happens on the coming edge.
    task automatic model_apply(input logic rst, input logic st, input logic jf,
                               input logic [7:0] ja, input logic rdy);
        logic [7:0] code;
        code = mem[m_pc];
        if (!rst) begin
            model_reset();
        end else if (m_mode == M_IDLE) begin
            if (st) begin
                m_mode = M_RUN;
                m_cnt  = 0;
            end
        end else if (jf) begin
            m_pc    = ja;
            m_valid = 1'b0;
            m_mode  = M_REDIR;
        end else if (m_mode == M_REDIR) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!m_valid || rdy) begin
                m_instr = code;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 8'd1) % 256;
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (code == 8'hFF) m_mode = M_HALT;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("imem_addr", int'(imem_addr), int'(m_pc));
        chk("instr_valid", int'(instr_valid), int'(m_valid));
        chk("busy", int'(busy), (m_mode == M_RUN || m_mode == M_REDIR) ? 1 : 0);
        chk("halted", int'(halted), (m_mode == M_HALT) ? 1 : 0);
        chk("fetch_cnt", int'(fetch_cnt), m_cnt);
        if (m_valid) begin
            chk("instr", int'(instr), int'(m_instr));
            chk("instr_pc", int'(instr_pc), int'(m_ipc));
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic jf,
                        input logic [7:0] ja, input logic rdy);
        reset       = rst;
        start       = st;
        jflag       = jf;
        jaddr       = ja;
        instr_ready = rdy;
        model_apply(rst, st, jf, ja, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, int'(imem_addr), 0);
        chk({tag, "_instr"}, int'(instr), 0);
        chk({tag, "_ipc"}, int'(instr_pc), 0);
        chk({tag, "_valid"}, int'(instr_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_cnt"}, int'(fetch_cnt), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        jflag       = 1'b0;
        jaddr       = 8'h00;
        instr_ready = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'(8'h10 + k);
        model_reset();
        #3;
        chk_reset_vals("por");
        @(negedge clk);

        // Sequential fetch
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("seq_cnt0", int'(fetch_cnt), 0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("seq_ipc0", int'(instr_pc), 0);
        chk("seq_instr0", int'(instr), 8'h10);
        run(3);
        chk("seq_ipc3", int'(instr_pc), 3);
        chk("seq_instr3", int'(instr), 8'h13);
        chk("seq_cnt4", int'(fetch_cnt), 4);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(negedge clk);
        compare_model();
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("rst_cnt0", int'(fetch_cnt), 0);
        run(3);
        chk("rst_ipc2", int'(instr_pc), 2);

        // Stall holds everything
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_ipc", int'(instr_pc), 2);
        chk("stall_addr", int'(imem_addr), 3);
        chk("stall_cnt", int'(fetch_cnt), 3);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("resume_ipc", int'(instr_pc), 3);
        run(1);
        chk("pc5", int'(imem_addr), 5);

        // Redirect, two bubble cycles
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b1);
        chk("redir_v0", int'(instr_valid), 0);
        run(1);
        chk("redir_v1", int'(instr_valid), 0);
        run(1);
        chk("redir_ipc", int'(instr_pc), 8'h40);
        chk("redir_instr", int'(instr), 8'h50);

        // Jump beats a halt word in the same cycle
        mem[8'h41] = 8'hFF;
        step(1'b1, 1'b0, 1'b1, 8'h60, 1'b1);
        chk("jhalt_halted", int'(halted), 0);
        chk("jhalt_busy", int'(busy), 1);
        mem[8'h41] = 8'h51;
        run(2);
        chk("jhalt_ipc", int'(instr_pc), 8'h60);

        // Halt opcode at address 7
        mem[7] = 8'hFF;
        step(1'b1, 1'b0, 1'b1, 8'h05, 1'b1);
        run(4);
        chk("halt_instr", int'(instr), 8'hFF);
        chk("halt_ipc", int'(instr_pc), 7);
        chk("halt_halted", int'(halted), 1);
        chk("halt_busy", int'(busy), 0);
        chk("halt_addr", int'(imem_addr), 8);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("halt_hold_v", int'(instr_valid), 1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("halt_drain_v", int'(instr_valid), 0);
        chk("halt_start_ign", int'(halted), 1);
        step(1'b1, 1'b0, 1'b1, 8'h20, 1'b1);
        run(2);
        chk("halt_exit_ipc", int'(instr_pc), 8'h20);
        mem[7] = 8'h17;

        // PC wrap
        step(1'b1, 1'b0, 1'b1, 8'hFE, 1'b1);
        run(2);
        chk("wrap_fe", int'(instr_pc), 8'hFE);
        run(1);
        chk("wrap_ff", int'(instr_pc), 8'hFF);
        run(1);
        chk("wrap_00", int'(instr_pc), 8'h00);
        chk("wrap_instr", int'(instr), 8'h10);

        // Counter saturation on a halt-free program
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        run(270);
        chk("cnt_sat", int'(fetch_cnt), 8'hFF);

        // Randomized traffic
        for (int k = 0; k < 256; k++)
            mem[k] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 14) == 0),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program counter and instruction-memory address width.
REQ-002 Parameter CODE_W, default 8, instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00, first fetch address after reset and in IDLE.
REQ-004 Parameter HALT_OP, default 8'hFF, opcode that stops fetching.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin fetching from RESET_PC; honoured only in IDLE.
REQ-008 jflag  input  1  jump/branch redirect request from execute, sampled each cycle.
REQ-009 jaddr  input  PC_W  redirect target, valid when jflag=1.
REQ-010 imem_code  input  CODE_W  combinational read data from instruction memory at imem_addr.
REQ-011 instr_ready  input  1  decode accepts instr this cycle.
REQ-012 imem_addr  output  PC_W  instruction-memory address, equal to internal pc.
REQ-013 instr  output  CODE_W  registered fetched instruction.
REQ-014 instr_pc  output  PC_W  address instr was fetched from.
REQ-015 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-016 busy  output  1  high in RUN or REDIRECT.
REQ-017 halted  output  1  high in HALT.
REQ-018 fetch_cnt  output  8  number of instructions delivered since start, saturating at 8'hFF.

Function
REQ-019 FSM states: IDLE, RUN, REDIRECT, HALT; one state active at a time.
REQ-020 IDLE: pc=RESET_PC, instr_valid=0; start=1 -> RUN, fetch_cnt cleared to 0; jflag ignored.
REQ-021 RUN, slot free (instr_valid=0 or instr_ready=1), jflag=0: instr<=imem_code, instr_pc<=pc, instr_valid<=1, pc<=pc+1, fetch_cnt+1.
REQ-022 RUN, stall (instr_valid=1 and instr_ready=0), jflag=0: pc, instr, instr_pc, instr_valid, fetch_cnt all hold.
REQ-023 pc increment is modulo 2^PC_W; 8'hFF+1 -> 8'h00 with no flag and no state change.
REQ-024 RUN load whose imem_code==HALT_OP: the halt word is delivered (instr_valid=1) and state -> HALT the same edge; no further pc increment.
REQ-025 jflag=1 in RUN, REDIRECT or HALT: pc<=jaddr, instr_valid<=0 (flush, regardless of instr_ready), no load that cycle, state -> REDIRECT.
REQ-026 REDIRECT: one bubble cycle, instr_valid stays 0, pc holds; next state RUN unless jflag=1 again (REQ-025 reapplies).
REQ-027 Redirect latency: instruction at jaddr appears with instr_valid=1 exactly 2 rising edges after the edge that sampled jflag, if instr_ready held 1.
REQ-028 jflag has priority over stall, normal load and HALT_OP detection in the same cycle.
REQ-029 HALT: no fetch, pc holds; the delivered halt word stays valid until accepted (instr_valid<=0 on instr_ready); exit only via jflag (-> REDIRECT) or reset.
REQ-030 start outside IDLE has no effect.
REQ-031 fetch_cnt increments only on a load into instr (REQ-021, REQ-024) and saturates at 8'hFF.
REQ-032 imem_addr is combinational from pc; no other output depends combinationally on any input.

Reset
REQ-033 reset=0 immediately forces state IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_cnt=0, busy=0, halted=0, independent of clk.
REQ-034 Reset asserted mid-RUN, mid-REDIRECT or in HALT discards any pending instruction and jump; after deassertion the block waits in IDLE for start.

Verification
REQ-035 Sequential fetch: memory addr k holds 8'h10+k, start pulse, instr_ready=1 -> instr_pc 0,1,2,3 with instr 8'h10..8'h13 on consecutive cycles, fetch_cnt=4.
REQ-036 Stall: instr_ready=0 for 3 cycles while instr_valid=1 at instr_pc=2 -> instr, instr_pc, imem_addr=3 and fetch_cnt frozen; resumes with instr_pc=3 after instr_ready=1.
REQ-037 Redirect: jflag=1, jaddr=8'h40 while at pc=5 -> instr_valid=0 for 2 cycles, then instr_pc=8'h40; simultaneous jflag and HALT_OP word -> no HALT, redirect taken.
REQ-038 Halt: HALT_OP at addr 7 -> instr=8'hFF at instr_pc=7, halted=1, busy=0, imem_addr stays 8; jflag jaddr=8'h20 -> resumes with instr_pc=8'h20.
REQ-039 Wrap: jump to 8'hFE with non-halt code at 8'hFE/8'hFF -> instr_pc 8'hFE, 8'hFF, 8'h00 consecutively.
REQ-040 Async reset: reset=0 between clock edges during RUN -> all outputs at reset values before next edge; start after release restarts at RESET_PC with fetch_cnt=0.
